exec_stage_pipe: RTL and testbench
==================================

# exec_stage_pipe

Parametrised, handshaked successor to the Y86-64 execute stage. It sits between decode and memory in the pipelined core and computes valE, the condition flag and the condition codes for every instruction class. It adds a registered output stage with valid/ready backpressure, a CC-write gate and a flush input, and can optionally include an iterative multi-cycle multiplier.

## Interface
- WIDTH, 64, datapath width in bits (≥8)
- STACK_STEP, 8, stack pointer adjust for call/ret/push/pop
- clk_i  in  1  clock, rising edge
- rst_n_i  in  1  asynchronous, active-low reset
- in_valid_i  in  1  decode presents an instruction
- in_ready_o  out  1  stage accepts this cycle
- icode_i, ifun_i  in  4 each  Y86 encodings (ICMOVQ=2, IIRMOVQ=3, IRMMOVQ=4, IMRMOVQ=5, IOPQ=6, IJXX=7, ICALL=8, IRET=9, IPUSHQ=A, IPOPQ=B)
- valA_i, valB_i, valC_i  in  WIDTH each  operands
- cc_en_i  in  1  sampled at acceptance; 0 suppresses the CC write for that instruction (a later stage has an exception)
- flush_i  in  1  discard in-flight work
- out_valid_o  out  1  result register holds a valid result
- out_ready_i  in  1  memory stage takes the result
- valE_o  out  WIDTH  ALU result
- cnd_o  out  1  branch/cmov condition
- cc_o  out  3  {ZF,SF,OF}

## Operation
- Operand select: OPq uses A=valA, B=valB. cmov uses A=valA, B=0. irmovq uses A=valC, B=0. rmmovq and mrmovq use A=valC, B=valB. call and push use A=−STACK_STEP, B=valB. ret and pop use A=+STACK_STEP, B=valB. All other icodes use A=B=0.
- Function: OPq uses ifun. Everything else uses ADD.
  - ADD: A+B.
  - SUB (ifun 1): B−A.
  - AND (2): A&B.
  - XOR (3): A^B.
  - All arithmetic is modulo 2^WIDTH.
- Flags (OPq only):
  - ZF = (E==0).
  - SF = E[WIDTH−1].
  - OF for ADD = (A[msb]==B[msb]) & (E[msb]!=A[msb]).
  - OF for SUB = (A[msb]!=B[msb]) & (E[msb]!=B[msb]).
  - OF for AND and XOR = 0.
- CC register: written when an OPq completes and cc_en was 1 at its acceptance. Undefined OPq ifun gives valE=0 and no CC write.
- cnd: computed from cc_o as it is at acceptance, for icode IJXX/ICMOVQ.
  - ifun 0 YES → 1.
  - 1 LE → (SF^OF)|ZF.
  - 2 L → SF^OF.
  - 3 E → ZF.
  - 4 NE → ~ZF.
  - 5 GE → ~(SF^OF).
  - 6 G → ~(SF^OF)&~ZF.
  - ifun >6 → 0.
  - All other icodes → 0.
- FSM: IDLE and BUSY. BUSY exists only with the multiplier compiled in.
- in_ready_o = IDLE & ~flush_i & (~out_valid_o | out_ready_i).
- Output register: holds valE/cnd stable while out_valid_o=1 and out_ready_i=0.
- Flush: clears out_valid_o at the next edge. It forces IDLE, aborting any multiply, and no CC write occurs for the aborted op. Flush takes priority over acceptance in the same cycle.
- Reset values: out_valid_o=0, valE_o=0, cnd_o=0, cc_o=3'b100, state IDLE. in_ready_o=1 once out of reset.
- Reset mid-operation: everything returns to the reset values immediately (asynchronous).

## Timing
- Single-cycle ops: accepted at edge N. out_valid_o, valE_o and cnd_o are valid after edge N. The CC is written at edge N, so an instruction accepted at N+1 sees the new flags.
- Throughput: one instruction per cycle when out_ready_i=1.
- Backpressure: a held result plus out_ready_i=0 → in_ready_o=0. A pop and a push in the same cycle are allowed.
- Multiply: latency WIDTH+1 edges from acceptance to out_valid_o. in_ready_o=0 throughout BUSY. The CC is written at completion.

## Configuration
- EXEC_MUL_EN defined:
  - OPq ifun 4 = MUL. It is an iterative shift-add over WIDTH cycles using a WIDTH-bit counter.
  - valE = low WIDTH bits of valA×valB (two's complement).
  - ZF and SF come from the result. OF=0.
- EXEC_MUL_EN undefined:
  - ifun 4 is undefined (valE=0, no CC write).
  - The FSM never leaves IDLE. All ops are single-cycle.

## Test plan
- Reset: assert rst_n_i=0 mid-stream → immediately out_valid_o=0, cc_o=3'b100. After release, in_ready_o=1.
- OPq SUB with valA=valB=5, then IJXX ifun 3 → valE_o=0, cc_o=3'b100. The jump yields cnd_o=1.
- OPq ADD with valA=0x7FFF_FFFF_FFFF_FFFF, valB=1 → valE_o=0x8000_0000_0000_0000, cc_o=3'b011. A following IJXX L (ifun 2) yields cnd_o=0.
- Backpressure: two back-to-back OPqs with out_ready_i=0 for 3 cycles → the first result is stable for 3 cycles and in_ready_o=0. The second is accepted on the cycle out_ready_i rises.
- Stack and CC gating:
  - pushq with valB=0x1000 → valE_o=0x0FF8.
  - popq with valB=0x1000 → valE_o=0x1008.
  - OPq XOR 1^1 with cc_en_i=0 → cc_o unchanged.
- EXEC_MUL_EN:
  - MUL with valA=6, valB=−7 → valE_o=0xFFFF_FFFF_FFFF_FFD6, out_valid_o 65 edges after acceptance.
  - Repeat with flush_i pulsed at cycle 10 → no result and cc_o unchanged.

Source files
------------

// File: rtl/exec_stage_pipe.sv
// exec_stage_pipe: Y86-64 execute stage with registered valid/ready output, CC gating and flush.
// Define EXEC_MUL_EN to add an iterative shift-add multiplier on OPq ifun 4.
module exec_stage_pipe #(
    parameter int WIDTH      = 64,
    parameter int STACK_STEP = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [3:0]       icode_i,
    input  logic [3:0]       ifun_i,
    input  logic [WIDTH-1:0] valA_i,
    input  logic [WIDTH-1:0] valB_i,
    input  logic [WIDTH-1:0] valC_i,
    input  logic             cc_en_i,
    input  logic             flush_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] valE_o,
    output logic             cnd_o,
    output logic [2:0]       cc_o
);
    localparam int M = WIDTH - 1;
    localparam logic S_IDLE = 1'b0;
    localparam logic S_BUSY = 1'b1;
    localparam logic [WIDTH-1:0] L_STEP = WIDTH'(STACK_STEP);
    localparam logic [WIDTH-1:0] L_CNT_END = WIDTH'(WIDTH);
`ifdef EXEC_MUL_EN
    localparam logic L_MUL_EN = 1'b1;
`else
    localparam logic L_MUL_EN = 1'b0;
`endif

    logic             r_state;
    logic             r_valid;
    logic [WIDTH-1:0] r_valE;
    logic             r_cnd;
    logic [2:0]       r_cc;
    logic             r_cc_en;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_cnt;

    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_e;
    logic [3:0]       w_fun;
    logic             w_is_op;
    logic             w_fun_ok;
    logic             w_is_mul;
    logic             w_zf;
    logic             w_sf;
    logic             w_of;
    logic             w_lt;
    logic             w_cond;
    logic             w_cnd;
    logic             w_accept;

    always_comb begin
        w_a = '0;
        w_b = '0;
        case (icode_i)
            4'h2: w_a = valA_i;
            4'h3: w_a = valC_i;
            4'h4, 4'h5: begin
                w_a = valC_i;
                w_b = valB_i;
            end
            4'h6: begin
                w_a = valA_i;
                w_b = valB_i;
            end
            4'h8, 4'hA: begin
                w_a = -L_STEP;
                w_b = valB_i;
            end
            4'h9, 4'hB: begin
                w_a = L_STEP;
                w_b = valB_i;
            end
            default: ;
        endcase
    end

    assign w_is_op  = icode_i == 4'h6;
    assign w_fun    = w_is_op ? ifun_i : 4'h0;
    assign w_fun_ok = (ifun_i < 4'h4) | (L_MUL_EN & (ifun_i == 4'h4));
    assign w_is_mul = w_is_op & L_MUL_EN & (ifun_i == 4'h4);
    assign w_e  = (w_fun == 4'h0) ? w_a + w_b :
                  (w_fun == 4'h1) ? w_b - w_a :
                  (w_fun == 4'h2) ? w_a & w_b :
                  (w_fun == 4'h3) ? w_a ^ w_b : '0;
    assign w_zf = w_e == '0;
    assign w_sf = w_e[M];
    assign w_of = (w_fun == 4'h0) ? (w_a[M] == w_b[M]) & (w_e[M] != w_a[M]) :
                  (w_fun == 4'h1) ? (w_a[M] != w_b[M]) & (w_e[M] != w_b[M]) : 1'b0;

    // Condition uses the flags as they stand at acceptance, i.e. the current CC register.
    assign w_lt = r_cc[1] ^ r_cc[0];
    always_comb begin
        w_cond = 1'b0;
        case (ifun_i)
            4'h0: w_cond = 1'b1;
            4'h1: w_cond = w_lt | r_cc[2];
            4'h2: w_cond = w_lt;
            4'h3: w_cond = r_cc[2];
            4'h4: w_cond = ~r_cc[2];
            4'h5: w_cond = ~w_lt;
            4'h6: w_cond = ~w_lt & ~r_cc[2];
            default: ;
        endcase
    end
    assign w_cnd = ((icode_i == 4'h7) | (icode_i == 4'h2)) & w_cond;

    assign in_ready_o = (r_state == S_IDLE) & ~flush_i & (~r_valid | out_ready_i);
    assign w_accept   = in_valid_i & in_ready_o;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state  <= S_IDLE;
            r_valid  <= 1'b0;
            r_valE   <= '0;
            r_cnd    <= 1'b0;
            r_cc     <= 3'b100;
            r_cc_en  <= 1'b0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else if (flush_i) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
        end else if (r_state == S_BUSY) begin
            if (r_cnt == L_CNT_END) begin
                r_state <= S_IDLE;
                r_valid <= 1'b1;
                r_valE  <= r_acc;
                r_cnd   <= 1'b0;
                if (r_cc_en)
                    r_cc <= {r_acc == '0, r_acc[M], 1'b0};
            end else begin
                r_acc    <= r_acc + (r_mplier[0] ? r_mcand : '0);
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + 1'b1;
            end
        end else if (w_accept) begin
            if (w_is_mul) begin
                r_state  <= S_BUSY;
                r_valid  <= 1'b0;
                r_cc_en  <= cc_en_i;
                r_acc    <= '0;
                r_mcand  <= valA_i;
                r_mplier <= valB_i;
                r_cnt    <= '0;
            end else begin
                r_valid <= 1'b1;
                r_valE  <= w_e;
                r_cnd   <= w_cnd;
                if (w_is_op & w_fun_ok & cc_en_i)
                    r_cc <= {w_zf, w_sf, w_of};
            end
        end else if (out_ready_i) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid_o = r_valid;
    assign valE_o      = r_valE;
    assign cnd_o       = r_cnd;
    assign cc_o        = r_cc;
endmodule

// File: tb/tb_exec_stage_pipe.sv
// tb_exec_stage_pipe: directed table, handshake corner cases and random traffic
// checked against a behavioural model of the execute stage.
module tb_exec_stage_pipe;
    localparam int W = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, in_valid, in_ready, cc_en, flush, out_valid, out_ready, cnd;
    logic [3:0]   icode, ifun;
    logic [W-1:0] va, vb, vc, vale;
    logic [2:0]   cc;
    int errors = 0;
    int checks = 0;

    exec_stage_pipe #(.WIDTH(W), .STACK_STEP(8)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .icode_i(icode), .ifun_i(ifun), .valA_i(va), .valB_i(vb), .valC_i(vc),
        .cc_en_i(cc_en), .flush_i(flush), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .valE_o(vale), .cnd_o(cnd), .cc_o(cc)
    );

    typedef struct packed {
        logic [W-1:0] e;
        logic         c;
        logic [2:0]   f;
    } res_t;

    typedef struct {
        logic [3:0]   ic;
        logic [3:0]   fn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] c;
        logic         en;
        logic [W-1:0] e;
        logic         cnd;
        logic [2:0]   cc;
    } vec_t;

    // Reference: results stated directly per instruction class, overflow from exact signed arithmetic.
    function automatic res_t ref_exec(input logic [3:0] ic, input logic [3:0] fn,
                                      input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic [W-1:0] c, input logic [2:0] cur, input logic en);
        res_t r;
        logic signed [W:0] s;
        logic [W-1:0] e;
        logic of, ok, lt;
        r.e = '0;
        r.c = 1'b0;
        r.f = cur;
        case (ic)
            4'h2: r.e = a;
            4'h3: r.e = c;
            4'h4, 4'h5: r.e = c + b;
            4'h8, 4'hA: r.e = b - 64'd8;
            4'h9, 4'hB: r.e = b + 64'd8;
            4'h6: begin
                ok = 1'b1;
                of = 1'b0;
                e = '0;
                case (fn)
                    4'h0: begin
                        e = a + b;
                        s = $signed({a[W-1], a}) + $signed({b[W-1], b});
                        of = s != $signed({e[W-1], e});
                    end
                    4'h1: begin
                        e = b - a;
                        s = $signed({b[W-1], b}) - $signed({a[W-1], a});
                        of = s != $signed({e[W-1], e});
                    end
                    4'h2: e = a & b;
                    4'h3: e = a ^ b;
                    default: ok = 1'b0;
                endcase
                r.e = e;
                if (ok && en)
                    r.f = {e == '0, e[W-1], of};
            end
            default: ;
        endcase
        if (ic == 4'h7 || ic == 4'h2) begin
            lt = cur[1] ^ cur[0];
            case (fn)
                4'h0: r.c = 1'b1;
                4'h1: r.c = lt | cur[2];
                4'h2: r.c = lt;
                4'h3: r.c = cur[2];
                4'h4: r.c = !cur[2];
                4'h5: r.c = !lt;
                4'h6: r.c = !lt && !cur[2];
                default: r.c = 1'b0;
            endcase
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [3:0] ic, input logic [3:0] fn, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] c, input logic en);
        icode = ic; ifun = fn; va = a; vb = b; vc = c; cc_en = en; in_valid = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    vec_t tv[21];
    res_t r;
    logic m_valid, m_c, exp_rdy, seen;
    logic [W-1:0] m_e, a, b;
    logic [2:0] m_cc;
    logic [3:0] ic, fn;
    int n;

    initial begin
        tv[0]  = '{4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 1'b1, 64'd0, 1'b0, 3'b100};
        tv[1]  = '{4'h7, 4'h3, 64'd0, 64'd0, 64'd0, 1'b1, 64'd0, 1'b1, 3'b100};
        tv[2]  = '{4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 64'h8000_0000_0000_0000, 1'b0, 3'b011};
        tv[3]  = '{4'h7, 4'h2, 64'd0, 64'd0, 64'd0, 1'b1, 64'd0, 1'b0, 3'b011};
        tv[4]  = '{4'hA, 4'h0, 64'd0, 64'h1000, 64'd0, 1'b1, 64'h0FF8, 1'b0, 3'b011};
        tv[5]  = '{4'hB, 4'h0, 64'd0, 64'h1000, 64'd0, 1'b1, 64'h1008, 1'b0, 3'b011};
        tv[6]  = '{4'h6, 4'h3, 64'd1, 64'd1, 64'd0, 1'b0, 64'd0, 1'b0, 3'b011};
        tv[7]  = '{4'h2, 4'h5, 64'h55, 64'h99, 64'd0, 1'b1, 64'h55, 1'b1, 3'b011};
        tv[8]  = '{4'h3, 4'h0, 64'd0, 64'h77, 64'h1234, 1'b1, 64'h1234, 1'b0, 3'b011};
        tv[9]  = '{4'h5, 4'h0, 64'd0, 64'h20, 64'h10, 1'b1, 64'h30, 1'b0, 3'b011};
        tv[10] = '{4'h6, 4'h2, 64'hF0F0, 64'hFF00, 64'd0, 1'b1, 64'hF000, 1'b0, 3'b000};
        tv[11] = '{4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, 64'd0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 3'b001};
        tv[12] = '{4'h7, 4'h6, 64'd0, 64'd0, 64'd0, 1'b1, 64'd0, 1'b0, 3'b001};
        tv[13] = '{4'h7, 4'h1, 64'd0, 64'd0, 64'd0, 1'b1, 64'd0, 1'b1, 3'b001};
        tv[14] = '{4'h6, 4'h7, 64'd3, 64'd4, 64'd0, 1'b1, 64'd0, 1'b0, 3'b001};
        tv[15] = '{4'h7, 4'h7, 64'd0, 64'd0, 64'd0, 1'b1, 64'd0, 1'b0, 3'b001};
        tv[16] = '{4'h9, 4'h0, 64'd0, 64'h2000, 64'd0, 1'b1, 64'h2008, 1'b0, 3'b001};
        tv[17] = '{4'h8, 4'h0, 64'd0, 64'h2000, 64'd0, 1'b1, 64'h1FF8, 1'b0, 3'b001};
        tv[18] = '{4'h4, 4'h0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd8, 1'b1, 64'd4, 1'b0, 3'b001};
        tv[19] = '{4'h0, 4'h0, 64'd1, 64'd2, 64'd3, 1'b1, 64'd0, 1'b0, 3'b001};
        tv[20] = '{4'h2, 4'h4, 64'd9, 64'd0, 64'd0, 1'b1, 64'd9, 1'b1, 3'b001};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0; cc_en = 1'b1;
        icode = '0; ifun = '0; va = '0; vb = '0; vc = '0;
        repeat (2) @(negedge clk);
        check("rst_valid", W'(out_valid), '0);
        check("rst_cc", W'(cc), W'(3'b100));
        check("rst_valE", vale, '0);
        rst_n = 1'b1;
        #1 check("rst_ready", W'(in_ready), W'(1'b1));

        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            issue(tv[i].ic, tv[i].fn, tv[i].a, tv[i].b, tv[i].c, tv[i].en);
            check($sformatf("tbl%0d_ready", i), W'(in_ready), W'(1'b1));
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            check($sformatf("tbl%0d_valid", i), W'(out_valid), W'(1'b1));
            check($sformatf("tbl%0d_valE", i), vale, tv[i].e);
            check($sformatf("tbl%0d_cnd", i), W'(cnd), W'(tv[i].cnd));
            check($sformatf("tbl%0d_cc", i), W'(cc), W'(tv[i].cc));
        end

        // Backpressure: first result held three cycles, second enters when ready rises.
        @(negedge clk);
        out_ready = 1'b0;
        issue(4'h6, 4'h0, 64'd1, 64'd2, 64'd0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        issue(4'h6, 4'h0, 64'd3, 64'd4, 64'd0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("bp%0d_valid", k), W'(out_valid), W'(1'b1));
            check($sformatf("bp%0d_valE", k), vale, 64'd3);
            check($sformatf("bp%0d_ready", k), W'(in_ready), '0);
            if (k < 2) begin
                @(posedge clk);
                @(negedge clk);
            end
        end
        out_ready = 1'b1;
        #1 check("bp_ready_rise", W'(in_ready), W'(1'b1));
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_second_valid", W'(out_valid), W'(1'b1));
        check("bp_second_valE", vale, 64'd7);
        check("bp_second_cc", W'(cc), W'(3'b000));

        // Flush beats a simultaneous acceptance and drops the held result.
        out_ready = 1'b0;
        issue(4'h6, 4'h1, 64'd2, 64'd2, 64'd0, 1'b1);
        flush = 1'b1;
        #1 check("flush_ready", W'(in_ready), '0);
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_valid", W'(out_valid), '0);
        check("flush_cc", W'(cc), W'(3'b000));

        // Asynchronous reset in the middle of traffic.
        issue(4'h6, 4'h0, 64'd5, 64'd6, 64'd0, 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", W'(out_valid), '0);
        check("arst_cc", W'(cc), W'(3'b100));
        check("arst_valE", vale, '0);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1 check("arst_ready", W'(in_ready), W'(1'b1));

        m_valid = 1'b0; m_cc = 3'b100; m_e = '0; m_c = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            check("rnd_valid", W'(out_valid), W'(m_valid));
            if (m_valid) begin
                check("rnd_valE", vale, m_e);
                check("rnd_cnd", W'(cnd), W'(m_c));
            end
            check("rnd_cc", W'(cc), W'(m_cc));
            ic = 4'($urandom_range(0, 15));
            fn = 4'($urandom_range(0, 7));
`ifdef EXEC_MUL_EN
            if (ic == 4'h6 && fn == 4'h4) fn = 4'h0;
`endif
            a = ($urandom_range(0, 3) == 0) ? 64'd5 : {$urandom, $urandom};
            b = ($urandom_range(0, 3) == 0) ? 64'd5 : {$urandom, $urandom};
            issue(ic, fn, a, b, {$urandom, $urandom}, $urandom_range(0, 4) != 0);
            in_valid = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 3) != 0;
            exp_rdy = !m_valid || out_ready;
            #1 check("rnd_ready", W'(in_ready), W'(exp_rdy));
            r = ref_exec(ic, fn, va, vb, vc, m_cc, cc_en);
            @(posedge clk);
            if (in_valid && exp_rdy) begin
                m_valid = 1'b1; m_e = r.e; m_c = r.c; m_cc = r.f;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
        end

        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        issue(4'h6, 4'h0, 64'd1, 64'd1, 64'd0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("pre_cc", W'(cc), W'(3'b000));
`ifdef EXEC_MUL_EN
        issue(4'h6, 4'h4, 64'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == 10) check("mul_busy_ready", W'(in_ready), '0);
        end
        check("mul_latency", W'(n), W'(65));
        check("mul_valE", vale, 64'hFFFF_FFFF_FFFF_FFD6);
        check("mul_cc", W'(cc), W'(3'b010));
        issue(4'h6, 4'h0, 64'd1, 64'd1, 64'd0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        issue(4'h6, 4'h4, 64'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        seen = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("mulflush_no_result", W'(seen), '0);
        check("mulflush_cc", W'(cc), W'(3'b000));
        check("mulflush_ready", W'(in_ready), W'(1'b1));
`else
        issue(4'h6, 4'h4, 64'd6, 64'd7, 64'd0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("undef4_valid", W'(out_valid), W'(1'b1));
        check("undef4_valE", vale, '0);
        check("undef4_cc", W'(cc), W'(3'b000));
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
